// File: rtl/synapse_access_arbiter_pkg.sv
// rtl/synapse_access_arbiter_pkg.sv - shared types for the synaptic weight RAM arbiter
package synapse_access_arbiter_pkg;

  // Phase of the single outstanding access; each name matches the cycle its outputs are visible
  typedef enum logic [1:0] {
    ST_ARB,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  // Which requester owns the access in flight
  typedef enum logic {
    OWN_HOST,
    OWN_SPK
  } owner_t;

  // Response codes carried on the *_rsp_err outputs
  localparam logic RSP_OKAY = 1'b0;
  localparam logic RSP_ERR  = 1'b1;

endpackage

// File: rtl/synapse_arb_select.sv
// rtl/synapse_arb_select.sv - spike-priority grant function with host-starvation burst counter
module synapse_arb_select #(
  parameter int MAX_SPIKE_BURST = 4,
  parameter int CNT_W           = $clog2(MAX_SPIKE_BURST + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic host_valid,
  input  logic spk_valid,
  input  logic arb_en,
  output logic grant_host,
  output logic grant_spk
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_SPIKE_BURST);

  logic [CNT_W-1:0] burst_cnt;
  logic             host_starved;

  // Spike wins unless the host has already watched MAX_SPIKE_BURST spike grants go by
  always_comb begin
    host_starved = host_valid && (burst_cnt == BURST_MAX);
    grant_spk    = spk_valid && !host_starved;
    grant_host   = host_valid && !grant_spk;
  end

  // Count spike grants taken while the host waits; any other grant clears the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (arb_en && (grant_spk || grant_host)) begin
      if (grant_spk && host_valid) begin
        burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/synapse_access_arbiter.sv
// rtl/synapse_access_arbiter.sv - shares the single-port synaptic weight RAM between host and spike engine
module synapse_access_arbiter #(
  parameter int NUM_SYNAPSES    = 207,
  parameter int ADDR_W          = 8,
  parameter int WEIGHT_W        = 16,
  parameter int TAG_W           = 8,
  parameter int MAX_SPIKE_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                host_req_valid,
  output logic                host_req_ready,
  input  logic                host_req_we,
  input  logic [ADDR_W-1:0]   host_req_addr,
  input  logic [WEIGHT_W-1:0] host_req_wdata,
  output logic                host_rsp_valid,
  input  logic                host_rsp_ready,
  output logic [WEIGHT_W-1:0] host_rsp_rdata,
  output logic                host_rsp_err,
  input  logic                spk_req_valid,
  output logic                spk_req_ready,
  input  logic [ADDR_W-1:0]   spk_req_addr,
  input  logic [TAG_W-1:0]    spk_req_tag,
  output logic                spk_rsp_valid,
  input  logic                spk_rsp_ready,
  output logic [WEIGHT_W-1:0] spk_rsp_weight,
  output logic [TAG_W-1:0]    spk_rsp_tag,
  output logic                spk_rsp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WEIGHT_W-1:0] mem_wdata,
  input  logic [WEIGHT_W-1:0] mem_rdata
);

  import synapse_access_arbiter_pkg::*;

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_SYNAPSES);

  arb_state_t          state, state_nx;
  owner_t              owner, owner_nx;
  logic                lat_we, lat_we_nx;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_nx;
  logic [WEIGHT_W-1:0] lat_wdata, lat_wdata_nx;
  logic [TAG_W-1:0]    lat_tag, lat_tag_nx;
  logic                lat_err, lat_err_nx;

  logic                host_req_ready_nx, spk_req_ready_nx;
  logic                mem_en_nx, mem_we_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [WEIGHT_W-1:0] mem_wdata_nx;
  logic                host_rsp_valid_nx, host_rsp_err_nx;
  logic [WEIGHT_W-1:0] host_rsp_rdata_nx;
  logic                spk_rsp_valid_nx, spk_rsp_err_nx;
  logic [WEIGHT_W-1:0] spk_rsp_weight_nx;
  logic [TAG_W-1:0]    spk_rsp_tag_nx;

  logic                accepted, rsp_done, arb_en, in_range, issue_rsp;
  logic                grant_host, grant_spk;
  logic [WEIGHT_W-1:0] rsp_data;

  // An ARB cycle with a ready pulse showing is the acceptance cycle, not a fresh arbitration slot
  assign accepted = host_req_ready || spk_req_ready;
  assign rsp_done = (host_rsp_valid && host_rsp_ready) || (spk_rsp_valid && spk_rsp_ready);
  assign arb_en   = ((state == ST_ARB) && !accepted) || ((state == ST_RESP) && rsp_done);
  assign in_range = ({1'b0, lat_addr} < ADDR_LIMIT);

  synapse_arb_select #(
    .MAX_SPIKE_BURST (MAX_SPIKE_BURST)
  ) u_select (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_valid (host_req_valid),
    .spk_valid  (spk_req_valid),
    .arb_en     (arb_en),
    .grant_host (grant_host),
    .grant_spk  (grant_spk)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_nx          = state;
    owner_nx          = owner;
    lat_we_nx         = lat_we;
    lat_addr_nx       = lat_addr;
    lat_wdata_nx      = lat_wdata;
    lat_tag_nx        = lat_tag;
    lat_err_nx        = lat_err;
    host_req_ready_nx = 1'b0;
    spk_req_ready_nx  = 1'b0;
    mem_en_nx         = 1'b0;
    mem_we_nx         = 1'b0;
    mem_addr_nx       = mem_addr;
    mem_wdata_nx      = mem_wdata;
    host_rsp_valid_nx = host_rsp_valid;
    host_rsp_rdata_nx = host_rsp_rdata;
    host_rsp_err_nx   = host_rsp_err;
    spk_rsp_valid_nx  = spk_rsp_valid;
    spk_rsp_weight_nx = spk_rsp_weight;
    spk_rsp_tag_nx    = spk_rsp_tag;
    spk_rsp_err_nx    = spk_rsp_err;
    issue_rsp         = 1'b0;
    rsp_data          = '0;

    case (state)
      ST_ARB: begin
        if (accepted) begin
          state_nx = ST_ACCESS;
          if (in_range) begin
            mem_en_nx    = 1'b1;
            mem_we_nx    = lat_we;
            mem_addr_nx  = lat_addr;
            mem_wdata_nx = lat_wdata;
            lat_err_nx   = RSP_OKAY;
          end else begin
            lat_err_nx   = RSP_ERR;
          end
        end
      end
      ST_ACCESS: begin
        state_nx  = lat_we ? ST_RESP : ST_WAIT;
        issue_rsp = lat_we;
      end
      ST_WAIT: begin
        state_nx  = ST_RESP;
        issue_rsp = 1'b1;
      end
      ST_RESP: begin
        if (rsp_done) begin
          host_rsp_valid_nx = 1'b0;
          spk_rsp_valid_nx  = 1'b0;
          state_nx          = ST_ARB;
        end
      end
      default: state_nx = ST_ARB;
    endcase

    if (issue_rsp) begin
      rsp_data = (lat_we || lat_err) ? '0 : mem_rdata;
      if (owner == OWN_HOST) begin
        host_rsp_valid_nx = 1'b1;
        host_rsp_rdata_nx = rsp_data;
        host_rsp_err_nx   = lat_err;
      end else begin
        spk_rsp_valid_nx  = 1'b1;
        spk_rsp_weight_nx = rsp_data;
        spk_rsp_tag_nx    = lat_tag;
        spk_rsp_err_nx    = lat_err;
      end
    end

    if (arb_en && grant_spk) begin
      spk_req_ready_nx = 1'b1;
      owner_nx         = OWN_SPK;
      lat_we_nx        = 1'b0;
      lat_addr_nx      = spk_req_addr;
      lat_wdata_nx     = '0;
      lat_tag_nx       = spk_req_tag;
    end else if (arb_en && grant_host) begin
      host_req_ready_nx = 1'b1;
      owner_nx          = OWN_HOST;
      lat_we_nx         = host_req_we;
      lat_addr_nx       = host_req_addr;
      lat_wdata_nx      = host_req_wdata;
      lat_tag_nx        = '0;
    end
  end

  // State, latched request and registered outputs; reset drops any access in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_ARB;
      owner          <= OWN_HOST;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_tag        <= '0;
      lat_err        <= RSP_OKAY;
      host_req_ready <= 1'b0;
      spk_req_ready  <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      host_rsp_valid <= 1'b0;
      host_rsp_rdata <= '0;
      host_rsp_err   <= 1'b0;
      spk_rsp_valid  <= 1'b0;
      spk_rsp_weight <= '0;
      spk_rsp_tag    <= '0;
      spk_rsp_err    <= 1'b0;
    end else begin
      state          <= state_nx;
      owner          <= owner_nx;
      lat_we         <= lat_we_nx;
      lat_addr       <= lat_addr_nx;
      lat_wdata      <= lat_wdata_nx;
      lat_tag        <= lat_tag_nx;
      lat_err        <= lat_err_nx;
      host_req_ready <= host_req_ready_nx;
      spk_req_ready  <= spk_req_ready_nx;
      mem_en         <= mem_en_nx;
      mem_we         <= mem_we_nx;
      mem_addr       <= mem_addr_nx;
      mem_wdata      <= mem_wdata_nx;
      host_rsp_valid <= host_rsp_valid_nx;
      host_rsp_rdata <= host_rsp_rdata_nx;
      host_rsp_err   <= host_rsp_err_nx;
      spk_rsp_valid  <= spk_rsp_valid_nx;
      spk_rsp_weight <= spk_rsp_weight_nx;
      spk_rsp_tag    <= spk_rsp_tag_nx;
      spk_rsp_err    <= spk_rsp_err_nx;
    end
  end

endmodule

// File: tb/tb_synapse_access_arbiter.sv
// tb/tb_synapse_access_arbiter.sv - directed self-checking bench for synapse_access_arbiter
module tb_synapse_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req_valid, host_req_ready, host_req_we;
  logic [7:0]  host_req_addr;
  logic [15:0] host_req_wdata;
  logic        host_rsp_valid, host_rsp_ready, host_rsp_err;
  logic [15:0] host_rsp_rdata;
  logic        spk_req_valid, spk_req_ready;
  logic [7:0]  spk_req_addr, spk_req_tag;
  logic        spk_rsp_valid, spk_rsp_ready, spk_rsp_err;
  logic [15:0] spk_rsp_weight;
  logic [7:0]  spk_rsp_tag;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] ram [0:255];
  logic [71:0] all_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  synapse_access_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_req_valid (host_req_valid),
    .host_req_ready (host_req_ready),
    .host_req_we    (host_req_we),
    .host_req_addr  (host_req_addr),
    .host_req_wdata (host_req_wdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_ready (host_rsp_ready),
    .host_rsp_rdata (host_rsp_rdata),
    .host_rsp_err   (host_rsp_err),
    .spk_req_valid  (spk_req_valid),
    .spk_req_ready  (spk_req_ready),
    .spk_req_addr   (spk_req_addr),
    .spk_req_tag    (spk_req_tag),
    .spk_rsp_valid  (spk_rsp_valid),
    .spk_rsp_ready  (spk_rsp_ready),
    .spk_rsp_weight (spk_rsp_weight),
    .spk_rsp_tag    (spk_rsp_tag),
    .spk_rsp_err    (spk_rsp_err),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  assign all_out = {host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
                    spk_req_ready, spk_rsp_valid, spk_rsp_weight, spk_rsp_tag, spk_rsp_err,
                    mem_en, mem_we, mem_addr, mem_wdata};

  // Single-port RAM: read data appears the cycle after a read enable
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_req(input string name, input bit is_spk, input bit we,
                         input logic [7:0] addr, input logic [15:0] wdata, input logic [7:0] tag,
                         input bit exp_en, input logic [15:0] exp_data, input bit exp_err);
    bit seen;
    @(negedge clk);
    if (is_spk) begin
      spk_req_valid = 1'b1; spk_req_addr = addr; spk_req_tag = tag;
    end else begin
      host_req_valid = 1'b1; host_req_we = we; host_req_addr = addr; host_req_wdata = wdata;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = is_spk ? spk_req_ready : host_req_ready;
    end
    check_eq({name, "/grant"}, seen, 1);
    if (!seen) begin
      spk_req_valid = 1'b0; host_req_valid = 1'b0;
      return;
    end
    check_eq({name, "/other_ready"}, is_spk ? host_req_ready : spk_req_ready, 0);
    @(negedge clk);
    spk_req_valid = 1'b0; host_req_valid = 1'b0;
    check_eq({name, "/mem_en"}, mem_en, exp_en);
    if (exp_en) check_eq({name, "/mem_cmd"}, {mem_we, mem_addr}, {we, addr});
    if (exp_en && we) check_eq({name, "/mem_wdata"}, mem_wdata, wdata);
    check_eq({name, "/early_rsp"}, is_spk ? spk_rsp_valid : host_rsp_valid, 0);
    if (!we) begin
      @(negedge clk);
      check_eq({name, "/wait_rsp"}, is_spk ? spk_rsp_valid : host_rsp_valid, 0);
    end
    @(negedge clk);
    if (is_spk)
      check_eq({name, "/rsp"}, {spk_rsp_valid, spk_rsp_weight, spk_rsp_err, spk_rsp_tag},
               {1'b1, exp_data, exp_err, tag});
    else
      check_eq({name, "/rsp"}, {host_rsp_valid, host_rsp_rdata, host_rsp_err},
               {1'b1, exp_data, exp_err});
    check_eq({name, "/mem_idle"}, mem_en, 0);
    @(negedge clk);
    check_eq({name, "/rsp_drop"}, is_spk ? spk_rsp_valid : host_rsp_valid, 0);
  endtask

  initial begin
    logic [9:0] seq;
    int ngr, cyc, first, last;
    bit seen;

    rst_n = 1'b0;
    host_req_valid = 1'b0; host_req_we = 1'b0; host_req_addr = '0; host_req_wdata = '0;
    host_rsp_ready = 1'b1;
    spk_req_valid = 1'b0; spk_req_addr = '0; spk_req_tag = '0;
    spk_rsp_ready = 1'b1;
    ram[206] <= 16'hBEEF;
    ram[20]  <= 16'h5A5A;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_out, 0);
    rst_n = 1'b1;

    run_req("t1_wr", 0, 1, 8'd5, 16'h1234, 8'h00, 1, 16'h0000, 0);
    run_req("t1_rd", 0, 0, 8'd5, 16'h0000, 8'h00, 1, 16'h1234, 0);
    run_req("t2_spk", 1, 0, 8'd206, 16'h0000, 8'h2A, 1, 16'hBEEF, 0);
    run_req("t3_host_oor", 0, 0, 8'd207, 16'h0000, 8'h00, 0, 16'h0000, 1);
    run_req("t3_host_wr_oor", 0, 1, 8'd207, 16'hFFFF, 8'h00, 0, 16'h0000, 1);
    run_req("t3_spk_oor", 1, 0, 8'd255, 16'h0000, 8'h3C, 0, 16'h0000, 1);

    @(negedge clk);
    spk_req_valid = 1'b1; spk_req_addr = 8'd10; spk_req_tag = 8'h01;
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 8'd5;
    seq = '0; ngr = 0; cyc = 0; first = 0; last = 0;
    for (int i = 0; i < 200 && ngr < 10; i++) begin
      @(negedge clk);
      cyc++;
      if (spk_req_ready || host_req_ready) begin
        check_eq("t4_ready_excl", spk_req_ready & host_req_ready, 0);
        seq = {seq[8:0], spk_req_ready};
        if (ngr == 0) first = cyc;
        last = cyc;
        ngr++;
      end
    end
    check_eq("t4_grant_count", ngr, 10);
    check_eq("t4_pattern", seq, 10'b1111011110);
    check_eq("t4_period", last - first, 36);
    @(negedge clk);
    spk_req_valid = 1'b0; host_req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t4_idle", {host_rsp_valid, spk_rsp_valid, host_req_ready, spk_req_ready}, 0);

    @(negedge clk);
    spk_rsp_ready = 1'b0;
    spk_req_valid = 1'b1; spk_req_addr = 8'd20; spk_req_tag = 8'h77;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = spk_req_ready;
    end
    check_eq("t5_grant", seen, 1);
    @(negedge clk);
    spk_req_valid = 1'b0;
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 8'd5;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_eq("t5_stall", {spk_rsp_valid, spk_rsp_weight, spk_rsp_tag, spk_rsp_err,
                            host_req_ready, spk_req_ready},
               {1'b1, 16'h5A5A, 8'h77, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end
    spk_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_release", {spk_rsp_valid, host_req_ready}, 2'b01);
    @(negedge clk);
    host_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_host_rsp", {host_rsp_valid, host_rsp_rdata, host_rsp_err}, {1'b1, 16'h1234, 1'b0});
    @(negedge clk);

    @(negedge clk);
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 8'd5;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = host_req_ready;
    end
    check_eq("t6_grant", seen, 1);
    @(negedge clk);
    host_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_reset_outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (host_rsp_valid || spk_rsp_valid) seen = 1'b1;
    end
    check_eq("t6_no_rsp", seen, 0);
    run_req("t6_fresh", 0, 0, 8'd5, 16'h0000, 8'h00, 1, 16'h1234, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/synapse_access_arbiter.md
Name: synapse_access_arbiter

Overview:
- Shares the single-port synaptic weight RAM between two requesters.
- Host port: configuration reads and writes arriving from the AXI4-Lite slave.
- Spike port: weight lookups issued by the spike-routing engine for each synapse touched by a fired neuron.
- One access outstanding at a time. Spike lookups have priority; a fairness counter bounds host starvation. Out-of-range addresses are rejected with an error response and no RAM access.

Parameters:
NUM_SYNAPSES, 207, weight RAM depth (entries)
ADDR_W, 8, synapse address width; must satisfy 2**ADDR_W >= NUM_SYNAPSES
WEIGHT_W, 16, weight width
TAG_W, 8, spike request tag width (post-neuron id), returned unchanged
MAX_SPIKE_BURST, 4, consecutive spike grants allowed while host is waiting

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
host_req_valid  in  1  host request valid
host_req_ready  out  1  host request accepted (1-cycle pulse)
host_req_we  in  1  1=write, 0=read
host_req_addr  in  ADDR_W  synapse index
host_req_wdata  in  WEIGHT_W  write data
host_rsp_valid  out  1  host response valid
host_rsp_ready  in  1  host response accepted
host_rsp_rdata  out  WEIGHT_W  read data (0 for writes/errors)
host_rsp_err  out  1  address out of range
spk_req_valid  in  1  spike lookup valid
spk_req_ready  out  1  spike lookup accepted (1-cycle pulse)
spk_req_addr  in  ADDR_W  synapse index
spk_req_tag  in  TAG_W  tag
spk_rsp_valid  out  1  weight response valid
spk_rsp_ready  in  1  weight response accepted
spk_rsp_weight  out  WEIGHT_W  weight (0 on error)
spk_rsp_tag  out  TAG_W  echoed tag
spk_rsp_err  out  1  address out of range
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  WEIGHT_W  RAM write data
mem_rdata  in  WEIGHT_W  RAM read data, valid the cycle after mem_en && !mem_we

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clock edge): state=ARB, burst counter=0, every output 0. Reset mid-transaction drops that transaction silently; no response is issued.
- States: ARB -> ACCESS -> (read: WAIT) -> RESP -> ARB.
- ARB:
  - Grant spike if spk_req_valid and not (host_req_valid and burst_cnt==MAX_SPIKE_BURST); otherwise grant host if host_req_valid.
  - The granted ready pulses high for exactly one cycle. Latch addr/we/wdata/tag and the owner.
  - Spike grant while host_req_valid is high: burst_cnt++ (saturating).
  - Host grant, or no host waiting: burst_cnt=0.
  - No request: stay in ARB; no ready pulse.
- ACCESS (acceptance cycle +1):
  - If latched addr < NUM_SYNAPSES: mem_en=1, mem_we=latched we (host only; spike requests are always reads), drive mem_addr/mem_wdata.
  - Otherwise: no RAM access; set the error flag.
  - Write -> RESP. Read -> WAIT.
- WAIT (+2): capture mem_rdata (or 0 on error) -> RESP.
- RESP: the owner's rsp_valid is high from the RESP-entry cycle (write +2, read +3) and holds with stable data until rsp_ready. rsp_valid falls at the cycle after the handshake, which is also when ARB is re-entered.
- The next grant occurs in that ARB cycle at the earliest. Throughput: one read per 4 cycles with rsp_ready held high.
- mem_en and mem_we are high only in ACCESS.
- host_req_ready and spk_req_ready are never high together.
- Out-of-range requests keep the same latency as in-range ones.
- Requests not granted in ARB are held by the requester; the block does not buffer them.

Decomposition:
- Shared package: arbiter state enum (ARB, ACCESS, WAIT, RESP), owner encoding (OWN_HOST, OWN_SPK), response codes.
- Sub-module: synapse_arb_select, a pure grant function of valids and burst_cnt, plus the burst counter. Unit-testable on its own.

Test Plan:
1. Host write addr 5 data 0x1234, then host read addr 5 -> mem_we pulse at +1 with addr 5; write rsp at +2 (err=0); read rsp rdata=0x1234 at +3.
2. Spike read addr 206 tag 0x2A with RAM preloaded 0xBEEF -> spk_rsp_valid at +3, weight 0xBEEF, tag 0x2A, err 0.
3. Host read addr 207 and spike read addr 255 -> no mem_en; err=1, data 0, same latencies as in-range.
4. spk_req_valid and host_req_valid both held high continuously, rsp_ready=1 -> grant pattern S,S,S,S,H repeating (MAX_SPIKE_BURST=4).
5. spk_rsp_ready held low 10 cycles -> rsp_valid, weight and tag stable; no further grants; the grant occurs in the cycle after ready rises.
6. rst_n asserted during WAIT -> all outputs 0 next cycle; no response; a fresh request completes normally after release.
